descrambler_byte_packer: RTL and testbench

DESCRAMBLER_BYTE_PACKER -- requirements
Module: descrambler_byte_packer

---
 rtl/descrambler_byte_packer_if.sv | 34 +++
 rtl/descrambler_byte_packer.sv | 131 +++++++++++++
 tb/tb_descrambler_byte_packer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/descrambler_byte_packer_if.sv
// rtl/descrambler_byte_packer_if.sv - frame control, bit input and byte output bundle (service_err under DESCRAMBLER_SERVICE_CHECK_EN)
interface descrambler_byte_packer_if #(
   parameter int LEN_W = 12
);
   logic             start;
   logic [LEN_W-1:0] psdu_length;
   logic             data_in;
   logic             valid_in;
   logic [7:0]       byte_out;
   logic             byte_valid;
   logic             last_byte;
   logic [6:0]       seed_out;
   logic             busy;
   logic             done;
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
   logic             service_err;
`endif

   modport master (
      output start, psdu_length, data_in, valid_in,
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
      input  service_err,
`endif
      input  byte_out, byte_valid, last_byte, seed_out, busy, done
   );

   modport slave (
      input  start, psdu_length, data_in, valid_in,
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
      output service_err,
`endif
      output byte_out, byte_valid, last_byte, seed_out, busy, done
   );
endinterface

// File: rtl/descrambler_byte_packer.sv
// rtl/descrambler_byte_packer.sv - recovers scrambler seed from SERVICE, descrambles PSDU bits and packs them LSB-first into bytes
// Optional SERVICE-bit check output service_err enabled by DESCRAMBLER_SERVICE_CHECK_EN.
module descrambler_byte_packer #(
   parameter int LEN_W     = 12,
   parameter int SEED_BITS = 7
) (
   input logic                      clk,
   input logic                      reset,
   descrambler_byte_packer_if.slave bus
);
   localparam int CNT_W    = LEN_W + 3;
   localparam int SVC_BITS = 16 - SEED_BITS;

   typedef enum logic [2:0] {IDLE, SEED, SERVICE, DATA, DONE} state_t;

   state_t           state;
   logic [7:1]       s;
   logic [CNT_W-1:0] bit_cnt;
   logic [LEN_W-1:0] len_q;
   logic [7:0]       shreg;
   logic             fb;
   logic             dbit;
   logic [7:0]       next_byte;
   logic [CNT_W-1:0] total_bits;
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
   logic             svc_acc;
`endif

   // Additive descrambler: state is fed by its own feedback, not by the received bit.
   assign fb         = s[7] ^ s[4];
   assign dbit       = bus.data_in ^ fb;
   assign next_byte  = {dbit, shreg[7:1]};
   assign total_bits = {len_q, 3'b000};

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         s              <= '0;
         bit_cnt        <= '0;
         len_q          <= '0;
         shreg          <= '0;
         bus.byte_out   <= '0;
         bus.byte_valid <= 1'b0;
         bus.last_byte  <= 1'b0;
         bus.seed_out   <= '0;
         bus.busy       <= 1'b0;
         bus.done       <= 1'b0;
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
         svc_acc         <= 1'b0;
         bus.service_err <= 1'b0;
`endif
      end else begin
         bus.byte_valid <= 1'b0;
         bus.last_byte  <= 1'b0;
         bus.done       <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state    <= SEED;
                  len_q    <= bus.psdu_length;
                  bit_cnt  <= '0;
                  shreg    <= '0;
                  bus.busy <= 1'b1;
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
                  svc_acc         <= 1'b0;
                  bus.service_err <= 1'b0;
`endif
               end
            end
            SEED: begin
               if (bus.valid_in) begin
                  s <= {s[6:1], bus.data_in};
                  if (bit_cnt == CNT_W'(SEED_BITS - 1)) begin
                     state        <= SERVICE;
                     bit_cnt      <= '0;
                     bus.seed_out <= {s[6:1], bus.data_in};
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            SERVICE: begin
               if (bus.valid_in) begin
                  s <= {s[6:1], fb};
                  if (bit_cnt == CNT_W'(SVC_BITS - 1)) begin
                     bit_cnt <= '0;
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
                     bus.service_err <= svc_acc | dbit;
`endif
                     if (len_q == '0) begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                     end else begin
                        state <= DATA;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
                     svc_acc <= svc_acc | dbit;
`endif
                  end
               end
            end
            DATA: begin
               if (bus.valid_in) begin
                  s       <= {s[6:1], fb};
                  shreg   <= next_byte;
                  bit_cnt <= bit_cnt + CNT_W'(1);
                  if (bit_cnt[2:0] == 3'd7) begin
                     bus.byte_out   <= next_byte;
                     bus.byte_valid <= 1'b1;
                  end
                  if (bit_cnt == total_bits - CNT_W'(1)) begin
                     bus.last_byte <= 1'b1;
                     state         <= DONE;
                     bus.done      <= 1'b1;
                     bus.busy      <= 1'b0;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_descrambler_byte_packer.sv
// tb/tb_descrambler_byte_packer.sv - scoreboard bench: scrambled frames in, expected bytes queued, monitor compares
module tb_descrambler_byte_packer;
   localparam int LEN_W = 12;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   descrambler_byte_packer_if #(.LEN_W(LEN_W)) bus_i ();

   descrambler_byte_packer #(.LEN_W(LEN_W), .SEED_BITS(7)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_i)
   );

   int errors = 0;
   int checks = 0;
   int done_seen = 0;
   int done_exp = 0;
   int flip_idx = -1;

   logic [7:0] exp_q[$];
   logic       exp_last_q[$];
   logic       tx_bits[$];
   logic [7:0] pay [0:3];
   logic [7:0] mon_b;
   logic       mon_l;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference 802.11 scrambler whose state after the 7 seed bits is 1011101.
   task automatic build(input int n);
      logic [6:0] st;
      logic       fbv;
      logic       inb;
      tx_bits.delete();
      st = 7'h5D;
      for (int i = 6; i >= 0; i--) tx_bits.push_back(st[i]);
      for (int k = 7; k < 16 + 8 * n; k++) begin
         inb = (k < 16) ? 1'b0 : pay[(k - 16) / 8][(k - 16) % 8];
         fbv = st[6] ^ st[3];
         tx_bits.push_back(inb ^ fbv ^ (k == flip_idx));
         st = {st[5:0], fbv};
      end
   endtask

   task automatic send(input int n, input int gap, input bit mid_start,
                       input bit start_with_valid, input int stop_at);
      int last_k;
      build(n);
      last_k = tx_bits.size() - 1;
      @(negedge clk);
      bus_i.start       = 1'b1;
      bus_i.psdu_length = LEN_W'(n);
      bus_i.valid_in    = start_with_valid;
      bus_i.data_in     = 1'b0;
      @(posedge clk); #1;
      check("busy_after_start", bus_i.busy, 1);
      for (int k = 0; k <= last_k; k++) begin
         if (k == stop_at) begin
            @(negedge clk);
            bus_i.valid_in = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            check("rst_byte_out", bus_i.byte_out, 0);
            check("rst_byte_valid", bus_i.byte_valid, 0);
            check("rst_last_byte", bus_i.last_byte, 0);
            check("rst_seed_out", bus_i.seed_out, 0);
            check("rst_busy", bus_i.busy, 0);
            check("rst_done", bus_i.done, 0);
            @(negedge clk);
            reset = 1'b0;
            repeat (20) @(negedge clk);
            return;
         end
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bus_i.valid_in = 1'b0;
            bus_i.start    = (mid_start && k == 30 && g == 0);
            if (mid_start && k == 30 && g == 0) bus_i.psdu_length = LEN_W'(1);
         end
         @(negedge clk);
         bus_i.start    = 1'b0;
         bus_i.valid_in = 1'b1;
         bus_i.data_in  = tx_bits[k];
         if (k >= 16 && (k - 16) % 8 == 7) begin
            exp_q.push_back(pay[(k - 16) / 8]);
            exp_last_q.push_back((k - 16) / 8 == n - 1);
         end
         if (k == last_k) done_exp++;
         if (k == 6) begin
            @(posedge clk); #1;
            check("seed_out", bus_i.seed_out, 7'h5D);
            check("busy_in_frame", bus_i.busy, 1);
         end
         if (k == last_k) begin
            @(posedge clk); #1;
            check("done_pulse", bus_i.done, 1);
            check("busy_at_done", bus_i.busy, 0);
`ifdef DESCRAMBLER_SERVICE_CHECK_EN
            check("service_err", bus_i.service_err, (flip_idx >= 7 && flip_idx < 16));
`endif
            @(posedge clk); #1;
            check("done_one_cycle", bus_i.done, 0);
         end
      end
      @(negedge clk);
      bus_i.valid_in = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && bus_i.byte_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_byte: got byte_valid with byte %0h, expected none", bus_i.byte_out);
         end else begin
            mon_b = exp_q.pop_front();
            mon_l = exp_last_q.pop_front();
            check("byte_out", bus_i.byte_out, mon_b);
            check("last_byte", bus_i.last_byte, mon_l);
         end
      end
      if (bus_i.done) done_seen++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_i.start       = 1'b0;
      bus_i.psdu_length = '0;
      bus_i.data_in     = 1'b0;
      bus_i.valid_in    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("init_byte_out", bus_i.byte_out, 0);
      check("init_byte_valid", bus_i.byte_valid, 0);
      check("init_last_byte", bus_i.last_byte, 0);
      check("init_seed_out", bus_i.seed_out, 0);
      check("init_busy", bus_i.busy, 0);
      check("init_done", bus_i.done, 0);
      @(negedge clk);
      reset = 1'b0;

      pay[0] = 8'h5A;
      send(1, 0, 1'b0, 1'b1, -1);

      pay[0] = 8'hA5; pay[1] = 8'h3C;
      send(2, 0, 1'b0, 1'b0, -1);

      send(0, 0, 1'b0, 1'b0, -1);
      repeat (3) @(negedge clk);
      check("busy_after_len0", bus_i.busy, 0);

      // tail/pad bits while idle must be ignored
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus_i.valid_in = 1'b1;
         bus_i.data_in  = i[0];
      end
      @(negedge clk);
      bus_i.valid_in = 1'b0;

      pay[0] = 8'h01; pay[1] = 8'h80; pay[2] = 8'hFF; pay[3] = 8'h00;
      send(4, 0, 1'b0, 1'b0, -1);
      send(4, 2, 1'b1, 1'b0, -1);

      pay[0] = 8'h11; pay[1] = 8'h22;
      send(2, 0, 1'b0, 1'b0, 27);

      pay[0] = 8'hC3; pay[1] = 8'h7E; pay[2] = 8'h99;
      send(3, 1, 1'b0, 1'b0, -1);

`ifdef DESCRAMBLER_SERVICE_CHECK_EN
      flip_idx = 10;
      pay[0] = 8'h42;
      send(1, 0, 1'b0, 1'b0, -1);
      flip_idx = -1;
      send(1, 0, 1'b0, 1'b0, -1);
`endif

      repeat (10) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      check("done_count", done_seen, done_exp);
      check("final_busy", bus_i.busy, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
